// File: rtl/arb_seq_gen_pkg.sv
// Shared definitions for the arbitrary-sequence generator.
//   MODE_*      traversal mode encodings on the mode input
//   dir_t       traversal direction used by PINGPONG
//   clamp_len   maps the raw seq_len input onto the legal range 1..depth
package arb_seq_pkg;

    localparam logic [1:0] MODE_WRAP     = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    function automatic int clamp_len(input int len, input int depth);
        if (len < 1) begin
            return 1;
        end
        if (len > depth) begin
            return depth;
        end
        return len;
    endfunction

endpackage

// File: rtl/arb_seq_gen_if.sv
// Control/table/output bundle of the arbitrary-sequence generator.
//   master : drives step, restart, mode, seq_len, wr_*; observes seq_out, seq_idx, wrap, done
//   slave  : the generator side of the same signals
interface arb_seq_gen_if #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) ();
    localparam int IW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic             step;
    logic             restart;
    logic [1:0]       mode;
    logic [LW-1:0]    seq_len;
    logic             wr_en;
    logic [IW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] seq_out;
    logic [IW-1:0]    seq_idx;
    logic             wrap;
    logic             done;

    modport master (
        output step, restart, mode, seq_len, wr_en, wr_addr, wr_data,
        input  seq_out, seq_idx, wrap, done
    );

    modport slave (
        input  step, restart, mode, seq_len, wr_en, wr_addr, wr_data,
        output seq_out, seq_idx, wrap, done
    );
endinterface

// File: rtl/arb_seq_gen_table.sv
// DEPTH x WIDTH code table. Reset loads the identity pattern (entry i holds
// i mod 2^WIDTH); one synchronous write port, one combinational read port.
//   clock, reset           rising-edge clock, synchronous active-high reset
//   i_wr_en/addr/data      write port, visible on the read port the next cycle
//   i_rd_addr, o_rd_data   combinational read port
module arb_seq_table #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [IW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [IW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= WIDTH'(i);
            end
        end else if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/arb_seq_gen.sv
// Programmable arbitrary-sequence generator: walks a run-time-programmable
// code table in WRAP, ONESHOT, PINGPONG or HOLD order and presents the code
// at the current index on registered outputs.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   bus (slave)   step/restart/mode/seq_len controls, table write port,
//                 seq_out/seq_idx/wrap/done outputs
module arb_seq_gen
    import arb_seq_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    arb_seq_gen_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);

    logic [IW-1:0]    r_idx;
    dir_t             r_dir;
    logic             r_done;
    logic             r_wrap;
    logic [WIDTH-1:0] r_seq_out;

    logic [IW-1:0]    w_last;
    logic [IW-1:0]    w_next_idx;
    dir_t             w_next_dir;
    logic             w_adv;
    logic             w_evt;
    logic             w_set_done;
    logic [IW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0] w_load_data;

    assign w_last = IW'(clamp_len(int'(bus.seq_len), DEPTH) - 1);

    // w_adv marks a step that is actually accepted; ignored steps (HOLD,
    // ONESHOT after done) leave index, direction and seq_out untouched.
    always_comb begin
        w_next_idx = r_idx;
        w_next_dir = r_dir;
        w_adv      = 1'b0;
        w_evt      = 1'b0;
        w_set_done = 1'b0;
        if (bus.step) begin
            case (bus.mode)
                MODE_WRAP: begin
                    w_adv = 1'b1;
                    if (r_idx < w_last) begin
                        w_next_idx = r_idx + IW'(1);
                    end else begin
                        w_next_idx = '0;
                        w_evt      = 1'b1;
                    end
                end
                MODE_ONESHOT: begin
                    if (!r_done) begin
                        w_adv = 1'b1;
                        if (r_idx < w_last) begin
                            w_next_idx = r_idx + IW'(1);
                        end else begin
                            w_set_done = 1'b1;
                            w_evt      = 1'b1;
                        end
                    end
                end
                MODE_PINGPONG: begin
                    w_adv = 1'b1;
                    if (w_last == '0) begin
                        w_next_idx = '0;
                        w_next_dir = DIR_UP;
                    end else if ((r_dir == DIR_UP) ? (r_idx >= w_last) : (r_idx > w_last)) begin
                        // Top turn-around; also catches an index stranded past a shortened length.
                        w_next_idx = w_last - IW'(1);
                        w_next_dir = DIR_DOWN;
                        w_evt      = 1'b1;
                    end else if (r_dir == DIR_UP) begin
                        w_next_idx = r_idx + IW'(1);
                    end else if (r_idx != '0) begin
                        w_next_idx = r_idx - IW'(1);
                    end else begin
                        w_next_idx = IW'(1);
                        w_next_dir = DIR_UP;
                        w_evt      = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_rd_addr   = bus.restart ? '0 : w_next_idx;
    // A write landing on the entry about to be loaded must win over the stale table read.
    assign w_load_data = (bus.wr_en && (bus.wr_addr == w_rd_addr)) ? bus.wr_data : w_rd_data;

    arb_seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_table (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (bus.wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx     <= '0;
            r_dir     <= DIR_UP;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
            r_seq_out <= '0;
        end else if (bus.restart) begin
            r_idx     <= '0;
            r_dir     <= DIR_UP;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
            r_seq_out <= w_load_data;
        end else begin
            r_wrap <= w_evt;
            if (w_adv) begin
                r_idx     <= w_next_idx;
                r_dir     <= w_next_dir;
                r_seq_out <= w_load_data;
            end
            if (bus.mode != MODE_ONESHOT) begin
                r_done <= 1'b0;
            end else if (w_set_done) begin
                r_done <= 1'b1;
            end
        end
    end

    assign bus.seq_out = r_seq_out;
    assign bus.seq_idx = r_idx;
    assign bus.wrap    = r_wrap;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_arb_seq_gen.sv
// Self-checking bench for arb_seq_gen: directed scenarios followed by random
// traffic, all compared against a behavioural model of the sequence rules.
module tb_arb_seq_gen;
    logic clock = 1'b0;
    logic reset = 1'b1;

    arb_seq_gen_if #(.WIDTH(3), .DEPTH(8)) bus ();

    arb_seq_gen #(.WIDTH(3), .DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_tbl [8];
    int m_idx, m_dir, m_done, m_wrap, m_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_out"},  32'(bus.seq_out), 32'(m_out));
        check({tag, "_idx"},  32'(bus.seq_idx), 32'(m_idx));
        check({tag, "_wrap"}, 32'(bus.wrap),    32'(m_wrap));
        check({tag, "_done"}, 32'(bus.done),    32'(m_done));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        bus.step = 1'b0; bus.restart = 1'b0; bus.wr_en = 1'b0;
        for (int i = 0; i < 8; i++) m_tbl[i] = i;
        m_idx = 0; m_dir = 1; m_done = 0; m_wrap = 0; m_out = 0;
        @(posedge clock); #1;
        check_outputs(tag);
        reset = 1'b0;
    endtask

    // One clock with the given inputs; model applied, then DUT checked #1 after the edge.
    task automatic cyc(input logic st, input logic rs, input logic [1:0] md, input logic [3:0] ln,
                       input logic we, input logic [2:0] wa, input logic [2:0] wd, input string tag);
        int len, last, nxt;
        bus.step = st; bus.restart = rs; bus.mode = md; bus.seq_len = ln;
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        len  = (int'(ln) < 1) ? 1 : ((int'(ln) > 8) ? 8 : int'(ln));
        last = len - 1;
        // Applying the write first makes a same-cycle load see the new data.
        if (we) m_tbl[wa] = int'(wd);
        m_wrap = 0;
        if (rs) begin
            m_idx = 0; m_dir = 1; m_done = 0; m_out = m_tbl[0];
        end else begin
            if (st) begin
                case (md)
                    2'd0: begin
                        if (m_idx < last) m_idx++;
                        else begin m_idx = 0; m_wrap = 1; end
                        m_out = m_tbl[m_idx];
                    end
                    2'd1: begin
                        if (m_done == 0) begin
                            if (m_idx < last) m_idx++;
                            else begin m_done = 1; m_wrap = 1; end
                            m_out = m_tbl[m_idx];
                        end
                    end
                    2'd2: begin
                        if (len == 1) begin
                            m_idx = 0; m_dir = 1;
                        end else begin
                            nxt = m_idx + m_dir;
                            if (m_idx > last) begin m_idx = last - 1; m_dir = -1; m_wrap = 1; end
                            else if (nxt > last) begin m_idx = m_idx - 1; m_dir = -1; m_wrap = 1; end
                            else if (nxt < 0) begin m_idx = 1; m_dir = 1; m_wrap = 1; end
                            else m_idx = nxt;
                        end
                        m_out = m_tbl[m_idx];
                    end
                    default: begin end
                endcase
            end
            if (md != 2'd1) m_done = 0;
        end
        @(posedge clock); #1;
        check_outputs(tag);
        bus.step = 1'b0; bus.restart = 1'b0; bus.wr_en = 1'b0;
    endtask

    int exp1 [8] = '{1, 2, 3, 6, 5, 7, 0, 1};
    int exp2 [6] = '{1, 2, 3, 3, 3, 3};
    int exp3 [6] = '{1, 2, 1, 0, 1, 2};
    int wdat [7] = '{0, 1, 2, 3, 6, 5, 7};

    initial begin
        logic [1:0] r_md;
        logic [3:0] r_ln;
        bus.step = 1'b0; bus.restart = 1'b0; bus.mode = 2'd0; bus.seq_len = 4'd7;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

        // 1) table load + WRAP over 7 entries
        do_reset("t1_rst");
        for (int i = 0; i < 7; i++) cyc(0, 0, 2'd0, 4'd7, 1, 3'(i), 3'(wdat[i]), "t1_wr");
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 2'd0, 4'd7, 0, 3'd0, 3'd0, $sformatf("t1_s%0d", i));
            check($sformatf("t1_seq%0d", i), 32'(bus.seq_out), 32'(exp1[i]));
            check($sformatf("t1_wrap%0d", i), 32'(bus.wrap), (i == 6) ? 32'd1 : 32'd0);
        end

        // 2) ONESHOT len 4
        do_reset("t2_rst");
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 2'd1, 4'd4, 0, 3'd0, 3'd0, $sformatf("t2_s%0d", i));
            check($sformatf("t2_idx%0d", i), 32'(bus.seq_idx), 32'(exp2[i]));
            check($sformatf("t2_done%0d", i), 32'(bus.done), (i >= 3) ? 32'd1 : 32'd0);
        end
        cyc(0, 1, 2'd1, 4'd4, 0, 3'd0, 3'd0, "t2_restart");
        check("t2_rs_done", 32'(bus.done), 32'd0);

        // 3) PINGPONG len 3
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 2'd2, 4'd3, 0, 3'd0, 3'd0, $sformatf("t3_s%0d", i));
            check($sformatf("t3_idx%0d", i), 32'(bus.seq_idx), 32'(exp3[i]));
            check($sformatf("t3_wrap%0d", i), 32'(bus.wrap), (i == 2 || i == 4) ? 32'd1 : 32'd0);
        end

        // 4) shrinking length mid-run, len 0 treated as 1
        cyc(0, 1, 2'd0, 4'd8, 0, 3'd0, 3'd0, "t4_rs");
        for (int i = 0; i < 5; i++) cyc(1, 0, 2'd0, 4'd8, 0, 3'd0, 3'd0, "t4_up");
        cyc(1, 0, 2'd0, 4'd3, 0, 3'd0, 3'd0, "t4_shrink");
        check("t4_shrink_idx", 32'(bus.seq_idx), 32'd0);
        check("t4_shrink_wrap", 32'(bus.wrap), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 2'd0, 4'd0, 0, 3'd0, 3'd0, "t4_len0");
            check("t4_len0_wrap", 32'(bus.wrap), 32'd1);
        end
        cyc(0, 0, 2'd0, 4'd0, 0, 3'd0, 3'd0, "t4_idle");

        // 5) write bypass and write to current entry
        cyc(0, 1, 2'd0, 4'd8, 0, 3'd0, 3'd0, "t5_rs");
        cyc(1, 0, 2'd0, 4'd8, 0, 3'd0, 3'd0, "t5_s1");
        cyc(1, 0, 2'd0, 4'd8, 1, 3'd2, 3'd7, "t5_bypass");
        check("t5_bypass_out", 32'(bus.seq_out), 32'd7);
        cyc(0, 0, 2'd0, 4'd8, 1, 3'd1, 3'd4, "t5_wr_nostep");
        check("t5_nostep_out", 32'(bus.seq_out), 32'd7);

        // 6) reset mid-run with done set and a modified table
        cyc(0, 1, 2'd1, 4'd2, 0, 3'd0, 3'd0, "t6_rs");
        for (int i = 0; i < 3; i++) cyc(1, 0, 2'd1, 4'd2, 0, 3'd0, 3'd0, "t6_os");
        check("t6_done_before", 32'(bus.done), 32'd1);
        do_reset("t6_rst");
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 2'd0, 4'd8, 0, 3'd0, 3'd0, "t6_id");
            check($sformatf("t6_ident%0d", i), 32'(bus.seq_out), 32'((i + 1) % 8));
        end
        for (int i = 0; i < 3; i++) cyc(1, 0, 2'd0, 4'd8, 0, 3'd0, 3'd0, "t6_adv");
        cyc(1, 1, 2'd0, 4'd8, 0, 3'd0, 3'd0, "t6_rs_step");
        check("t6_rs_wins", 32'(bus.seq_idx), 32'd0);

        // Random traffic against the model
        r_md = 2'd0;
        r_ln = 4'd8;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset("rnd_rst");
            end else begin
                if ($urandom_range(0, 15) == 0) r_md = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 11) == 0) r_ln = 4'($urandom_range(0, 15));
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, r_md, r_ln,
                    $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    $sformatf("rnd%0d", i));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
